uart_alu_interface: RTL and testbench
=====================================

UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8, width of UART bytes and of the ALU operands and result.
- CMD_CONFIG, 8'hCD, command byte that opens an operand/opcode load.
- CMD_DISPLAY, 8'hD1, command byte that requests the result and flags.
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles tolerated between bytes of one config sequence.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; one clock domain.
- reset, in, 1, synchronous, active-high reset.
- rx_data, in, DATA_WIDTH, byte from the UART receiver.
- rx_done, in, 1, one-cycle pulse; rx_data is valid in that cycle.
- tx_busy, in, 1, UART transmitter is busy.
- tx_done, in, 1, one-cycle pulse at the end of the transmitter's stop bit.
- alu_result, in, DATA_WIDTH, result from the combinational ALU.
- alu_zero, in, 1, ALU zero flag.
- alu_overflow, in, 1, ALU signed-overflow flag.
- alu_a, out, DATA_WIDTH, registered operand A.
- alu_b, out, DATA_WIDTH, registered operand B.
- alu_op, out, 6, registered opcode (low 6 bits of the opcode byte).
- tx_data, out, DATA_WIDTH, byte to transmit.
- tx_start, out, 1, one-cycle request to transmit tx_data.
- busy, out, 1, high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have these states: IDLE, GET_A, GET_B, GET_OP, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-004 In IDLE:
- rx_done with rx_data==CMD_CONFIG -> GET_A.
- rx_done with rx_data==CMD_DISPLAY -> SEND_RES; in the same edge, snapshot alu_result into res_q and {6'b0, alu_overflow, alu_zero} into flg_q.
- rx_done with any other byte -> remain in IDLE; no other effect.
REQ-005 GET_A and GET_B SHALL store rx_data into shadow registers a_s and b_s on rx_done, then advance to GET_B and GET_OP respectively.
REQ-006 In GET_OP, on rx_done, alu_a, alu_b and alu_op SHALL update atomically in one edge (alu_a<=a_s, alu_b<=b_s, alu_op<=rx_data[5:0]), and the FSM SHALL return to IDLE.
REQ-007 alu_a, alu_b and alu_op SHALL NOT change at any time other than the GET_OP commit or reset.
REQ-008 Timeout:
- A counter SHALL clear on every rx_done and on entry to GET_A.
- The counter SHALL increment each cycle spent in GET_A, GET_B or GET_OP.
- When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE, discard a_s and b_s, and leave the ALU outputs unchanged.
REQ-009 SEND_RES: when tx_busy==0, drive tx_data=res_q and tx_start=1 for exactly one cycle, then go to WAIT_RES. While tx_busy==1, hold in SEND_RES with tx_start=0.
REQ-010 WAIT_RES: on tx_done -> SEND_FLG. SEND_FLG behaves as SEND_RES, using flg_q, then goes to WAIT_FLG. WAIT_FLG: on tx_done -> IDLE.
REQ-011 A rx_done arriving in SEND_RES, WAIT_RES, SEND_FLG or WAIT_FLG SHALL be ignored. It SHALL NOT be queued or interpreted later.
REQ-012 The transmitted result and flags SHALL be the snapshot values, even if the ALU inputs change during transmission.
REQ-013 Latency: tx_start for the result SHALL assert 1 clk after the DISPLAY rx_done when tx_busy==0. tx_start for the flags SHALL assert 1 clk after the first tx_done when tx_busy==0.
REQ-014 tx_data SHALL hold its value from the tx_start cycle until the next tx_start.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 While reset==1 at a clk edge:
- state SHALL go to IDLE.
- alu_a, alu_b, alu_op, a_s, b_s, res_q, flg_q, tx_data and the timeout counter SHALL go to 0.
- tx_start and busy SHALL go to 0.
REQ-017 Reset asserted mid-sequence or mid-transmission SHALL abort the operation with no further tx_start. The first byte accepted after reset SHALL be treated as a command.

Verification
REQ-018 Bytes CD,05,0A,20 -> alu_a=05, alu_b=0A, alu_op=20, all updated on the same edge. Then D1 with alu_result=0F, zero=0, ovf=0 -> tx_start pulses with tx_data=0F, then 00.
REQ-019 CD,64,64,22 then D1 with alu_result=00, zero=1 -> transmitted 00, then 01. With alu_result=96, ovf=1 -> transmitted 96, then 02.
REQ-020 Byte 55 in IDLE -> no tx_start, busy stays 0, ALU outputs unchanged.
REQ-021 CD,07 followed by TIMEOUT_CYCLES idle cycles (TIMEOUT_CYCLES overridden to 100) -> busy drops to 0 and alu_a keeps its old value. A following D1 is then serviced normally.
REQ-022 D1, then change alu_result and inject rx_done 20 during WAIT_RES -> the transmitted bytes are the snapshot values, and the injected byte has no effect.
REQ-023 Reset asserted in WAIT_RES -> next cycle busy=0 and tx_start=0, all registered outputs=0. No flags byte is sent.

Source files
------------

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: UART command decoder that loads ALU operands and sends back result and flags.
module uart_alu_interface #(
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_CONFIG = 8'hCD,
    parameter logic [DATA_WIDTH-1:0] CMD_DISPLAY = 8'hD1,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    output logic                  busy
);
    localparam logic [2:0] IDLE = 3'd0, GET_A = 3'd1, GET_B = 3'd2, GET_OP = 3'd3,
                           SEND_RES = 3'd4, WAIT_RES = 3'd5, SEND_FLG = 3'd6, WAIT_FLG = 3'd7;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [2:0] state, state_d;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] a_s, b_s, res_q, flg_q;
    logic timeout, in_get, sending;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign in_get = state == GET_A || state == GET_B || state == GET_OP;
    assign sending = (state == SEND_RES || state == SEND_FLG) && !tx_busy;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:     state_d = !rx_done ? IDLE : rx_data == CMD_CONFIG ? GET_A :
                                rx_data == CMD_DISPLAY ? SEND_RES : IDLE;
            GET_A:    state_d = rx_done ? GET_B : timeout ? IDLE : GET_A;
            GET_B:    state_d = rx_done ? GET_OP : timeout ? IDLE : GET_B;
            GET_OP:   state_d = rx_done || timeout ? IDLE : GET_OP;
            SEND_RES: state_d = tx_busy ? SEND_RES : WAIT_RES;
            WAIT_RES: state_d = tx_done ? SEND_FLG : WAIT_RES;
            SEND_FLG: state_d = tx_busy ? SEND_FLG : WAIT_FLG;
            default:  state_d = tx_done ? IDLE : WAIT_FLG;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_s      <= '0;
            b_s      <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            busy     <= state_d != IDLE;
            tx_start <= sending;
            cnt      <= (!in_get || rx_done || timeout) ? '0 : cnt + 1'b1;
            if (state == IDLE && rx_done && rx_data == CMD_DISPLAY) begin
                res_q <= alu_result;
                flg_q <= {{(DATA_WIDTH-2){1'b0}}, alu_overflow, alu_zero};
            end
            if (state == GET_A && rx_done) a_s <= rx_data;
            if (state == GET_B && rx_done) b_s <= rx_data;
            // an abandoned sequence leaves no stale operands behind
            if (in_get && !rx_done && timeout) begin
                a_s <= '0;
                b_s <= '0;
            end
            if (state == GET_OP && rx_done) begin
                alu_a  <= a_s;
                alu_b  <= b_s;
                alu_op <= rx_data[5:0];
            end
            if (sending) tx_data <= state == SEND_RES ? res_q : flg_q;
        end
    end
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: directed bench with an expected-byte queue and operand model checked every cycle.
module tb_uart_alu_interface;
    localparam int TO = 100;
    logic clk = 0, reset = 1, rx_done = 0, tx_done = 0, emu_busy = 0, ext_busy = 0;
    logic alu_zero = 0, alu_overflow = 0, tx_start, busy, tx_busy, prev_start = 0;
    logic [7:0] rx_data = 0, alu_result = 0, alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic [7:0] exp_a = 0, exp_b = 0;
    logic [5:0] exp_op = 0;
    logic [7:0] expq[$], txlog[$];
    int tests = 0, fails = 0;
    assign tx_busy = emu_busy | ext_busy;
    always #5 clk = ~clk;
    uart_alu_interface #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .tx_done(tx_done), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .tx_data(tx_data), .tx_start(tx_start), .busy(busy)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // every cycle: operands must match the model, each tx_start must carry the next expected byte
    initial forever begin
        @(posedge clk);
        #1;
        chk("alu_a", alu_a, exp_a);
        chk("alu_b", alu_b, exp_b);
        chk("alu_op", alu_op, exp_op);
        if (tx_start) begin
            chk("tx_start_single_cycle", prev_start, 0);
            if (expq.size() == 0) chk("tx_start_unexpected", tx_start, 0);
            else chk("tx_data", tx_data, expq.pop_front());
            txlog.push_back(tx_data);
        end
        prev_start = tx_start;
    end
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            emu_busy = 1;
            repeat (3) @(negedge clk);
            tx_done = 1;
            @(negedge clk);
            tx_done = 0;
            emu_busy = 0;
        end
    end
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1;
        @(negedge clk);
        rx_done = 0;
    endtask
    task automatic cfg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send(8'hCD);
        send(a);
        send(b);
        @(negedge clk);
        rx_data = op;
        rx_done = 1;
        exp_a = a;
        exp_b = b;
        exp_op = op[5:0];
        @(negedge clk);
        rx_done = 0;
    endtask
    task automatic wait_idle;
        int n = 0;
        while ((expq.size() != 0 || busy || tx_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_bound", n < 1000, 1);
    endtask
    task automatic disp(input logic [7:0] res, input logic z, input logic o);
        alu_result = res;
        alu_zero = z;
        alu_overflow = o;
        expq.push_back(res);
        expq.push_back({6'b0, o, z});
        send(8'hD1);
        @(posedge clk);
        #1 chk("result_latency", tx_start, 1);
    endtask
    task automatic chk_log(input string nm, input logic [7:0] b0, input logic [7:0] b1);
        int n = txlog.size();
        chk({nm, "_count"}, n >= 2, 1);
        if (n >= 2) begin
            chk({nm, "_res"}, txlog[n-2], b0);
            chk({nm, "_flg"}, txlog[n-1], b1);
        end
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_alu_a", alu_a, 8'h00);
        @(negedge clk) reset = 0;
        cfg(8'h05, 8'h0A, 8'h20);
        chk("cfg1_a", alu_a, 8'h05);
        chk("cfg1_b", alu_b, 8'h0A);
        chk("cfg1_op", alu_op, 6'h20);
        chk("cfg1_busy", busy, 0);
        disp(8'h0F, 0, 0);
        wait_idle();
        chk_log("disp1", 8'h0F, 8'h00);
        cfg(8'h64, 8'h64, 8'h22);
        chk("cfg2_op", alu_op, 6'h22);
        disp(8'h00, 1, 0);
        wait_idle();
        chk_log("disp_zero", 8'h00, 8'h01);
        disp(8'h96, 0, 1);
        wait_idle();
        chk_log("disp_ovf", 8'h96, 8'h02);
        send(8'h55);
        repeat (5) begin
            @(posedge clk);
            #1 chk("junk_busy", busy, 0);
        end
        chk("junk_alu_a", alu_a, 8'h64);
        send(8'hCD);
        send(8'h07);
        repeat (TO - 1) @(posedge clk);
        #1 chk("timeout_not_yet", busy, 1);
        @(posedge clk);
        #1 chk("timeout_busy_drop", busy, 0);
        chk("timeout_alu_a", alu_a, 8'h64);
        disp(8'h3C, 0, 0);
        wait_idle();
        chk_log("after_timeout", 8'h3C, 8'h00);
        disp(8'h33, 0, 0);
        alu_result = 8'hAA;
        alu_zero = 1;
        alu_overflow = 1;
        send(8'h20);
        wait_idle();
        chk_log("snapshot", 8'h33, 8'h00);
        repeat (5) @(negedge clk);
        chk("inject_busy", busy, 0);
        ext_busy = 1;
        alu_result = 8'h5A;
        alu_zero = 0;
        alu_overflow = 0;
        expq.push_back(8'h5A);
        expq.push_back(8'h00);
        send(8'hD1);
        repeat (4) begin
            @(posedge clk);
            #1 chk("hold_no_start", tx_start, 0);
            chk("hold_busy", busy, 1);
        end
        @(negedge clk) ext_busy = 0;
        @(posedge clk);
        #1 chk("hold_release_start", tx_start, 1);
        wait_idle();
        chk_log("hold", 8'h5A, 8'h00);
        alu_result = 8'h77;
        expq.push_back(8'h77);
        send(8'hD1);
        @(posedge clk);
        #1 chk("pre_reset_start", tx_start, 1);
        @(negedge clk);
        reset = 1;
        exp_a = 0;
        exp_b = 0;
        exp_op = 0;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_tx_data", tx_data, 0);
        @(negedge clk) reset = 0;
        repeat (12) @(negedge clk);
        chk("midrst_no_flags", txlog[txlog.size()-1], 8'h77);
        disp(8'h11, 0, 1);
        wait_idle();
        chk_log("post_reset", 8'h11, 8'h02);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
